// File: rtl/pe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_ctrl_pkg
//  Description : Shared control definitions for the binary-weight PE column:
//                B-bus command codes, field positions, word builders and the
//                one-hot sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_ctrl_pkg;

  // Command codes carried in the CMD field when FL=1.
  localparam logic [2:0] CMD_WGT  = 3'd0;
  localparam logic [2:0] CMD_RSET = 3'd1;
  localparam logic [2:0] CMD_ALT2 = 3'd2;
  localparam logic [2:0] CMD_INTM = 3'd3;
  localparam logic [2:0] CMD_LOAD = 3'd4;
  localparam logic [2:0] CMD_MULT = 3'd5;

  // Field positions that do not depend on the bus width.
  localparam int CMD_LSB = 1;
  localparam int IDX_LSB = 4;

  // One-hot sequencer states.
  localparam int         STATE_W = 8;
  localparam logic [7:0] S_IDLE  = 8'b0000_0001;
  localparam logic [7:0] S_RSET  = 8'b0000_0010;
  localparam logic [7:0] S_LOAD  = 8'b0000_0100;
  localparam logic [7:0] S_WGT   = 8'b0000_1000;
  localparam logic [7:0] S_MULT  = 8'b0001_0000;
  localparam logic [7:0] S_BIAS  = 8'b0010_0000;
  localparam logic [7:0] S_ALT2  = 8'b0100_0000;
  localparam logic [7:0] S_DRAIN = 8'b1000_0000;

  // Container wide enough for any supported bus width; callers truncate.
  typedef logic [31:0] bword_t;

  // Control word: FL set at bit nb-1, command in CMD, everything else zero.
  function automatic bword_t mk_ctrl(input int unsigned nb, input logic [2:0] cmd);
    bword_t w;
    w = '0;
    w[CMD_LSB+2:CMD_LSB] = cmd;
    w = w | (bword_t'(1) << (nb - 1));
    return w;
  endfunction

  // Weight word: FL set, CMD=0, row index in IDX, weight in bit 0.
  function automatic bword_t mk_wgt(input int unsigned nb, input logic [27:0] idx,
                                    input logic wbit);
    bword_t w;
    w = '0;
    w[31:IDX_LSB] = idx;
    w[CMD_LSB+2:CMD_LSB] = CMD_WGT;
    w[0] = wbit;
    w = w | (bword_t'(1) << (nb - 1));
    return w;
  endfunction

  // Bias word: FL clear, FP16 payload in the low half.
  function automatic bword_t mk_bias(input logic [15:0] data);
    bword_t w;
    w = '0;
    w[15:0] = data;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_seq_valid_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : pe_seq_valid_pipe
//  Description : DEPTH-stage valid delay line. Tracks which cycles carry a
//                bias word through the PE column so the result at the column
//                bottom can be captured without looking at its contents.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_seq_valid_pipe #(
  parameter int DEPTH = 17
) (
  input  logic clk,
  input  logic rst_n,
  input  logic valid_i,
  output logic cap_o,
  output logic valid_o,
  output logic empty_o
);

  logic [DEPTH-1:0] pipe_q;

  // Shift the valid marker one stage per cycle; reset flushes every stage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pipe_q <= '0;
    end else begin
      pipe_q <= {pipe_q[DEPTH-2:0], valid_i};
    end
  end

  // Second-to-last stage enables data capture so data and valid leave together.
  assign cap_o   = pipe_q[DEPTH-2];
  assign valid_o = pipe_q[DEPTH-1];
  assign empty_o = ~|pipe_q;

endmodule
`default_nettype wire

// File: rtl/pe_column_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : pe_column_sequencer
//  Description : Drives the B bus of one PE column (RSET, LOAD, weights,
//                MULT, bias stream, ALT2) and captures the column results.
//                Optional feature macro: PE_SEQ_PERF_EN adds perf_cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_column_sequencer
  import pe_ctrl_pkg::*;
#(
  parameter int NB   = 17,
  parameter int NID  = 7,
  parameter int ROWS = 16,
  parameter int VLW  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           skip_load,
  input  logic [VLW-1:0] vec_len,
  input  logic           w_valid,
  output logic           w_ready,
  input  logic           w_bit,
  input  logic           bb_valid,
  output logic           bb_ready,
  input  logic [15:0]    bb_data,
  output logic [NB-1:0]  b_out,
  output logic           act_en,
  input  logic [NB-1:0]  d_in,
  output logic           r_valid,
  output logic [15:0]    r_data,
  output logic           busy,
  output logic           done,
  output logic           err_underflow
`ifdef PE_SEQ_PERF_EN
  ,
  output logic [31:0]    perf_cycles
`endif
);

  // Counter wide enough for ROWS+1 (drain length) when ROWS = 2^NID.
  localparam int CW = NID + 1;

  localparam logic [NB-1:0] W_RSET = NB'(mk_ctrl(NB, CMD_RSET));
  localparam logic [NB-1:0] W_LOAD = NB'(mk_ctrl(NB, CMD_LOAD));
  localparam logic [NB-1:0] W_MULT = NB'(mk_ctrl(NB, CMD_MULT));
  localparam logic [NB-1:0] W_ALT2 = NB'(mk_ctrl(NB, CMD_ALT2));

  logic [STATE_W-1:0] state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [VLW-1:0]     vcnt_q, vcnt_d;
  logic [NB-1:0]      b_out_q, b_out_d;
  logic               act_en_q, act_en_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [15:0]        r_data_q;
  logic               pipe_cap, pipe_valid, pipe_empty;

  // Next-state and B-bus word selection; the word is registered one cycle later.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vcnt_d   = vcnt_q;
    b_out_d  = '0;
    act_en_d = 1'b0;
    done_d   = 1'b0;
    err_d    = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          err_d   = 1'b0;
          vcnt_d  = vec_len;
          state_d = skip_load ? S_MULT : S_RSET;
        end
      end
      S_RSET: begin
        b_out_d = W_RSET;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        b_out_d = W_LOAD;
        cnt_d   = CW'(ROWS - 1);
        state_d = S_WGT;
      end
      S_WGT: begin
        // Rows go bottom-up: a loaded PE blocks everything addressed below it.
        if (w_valid) begin
          b_out_d = NB'(mk_wgt(NB, 28'(cnt_q[NID-1:0]), w_bit));
          if (cnt_q == '0) begin
            state_d = S_MULT;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end
      end
      S_MULT: begin
        b_out_d = W_MULT;
        state_d = (vcnt_q == '0) ? S_ALT2 : S_BIAS;
      end
      S_BIAS: begin
        // The column cannot stall here; a missing bias word becomes zero.
        act_en_d = 1'b1;
        b_out_d  = NB'(mk_bias(bb_valid ? bb_data : 16'h0000));
        if (!bb_valid) begin
          err_d = 1'b1;
        end
        vcnt_d = vcnt_q - VLW'(1);
        if (vcnt_q == VLW'(1)) begin
          state_d = S_ALT2;
        end
      end
      S_ALT2: begin
        b_out_d = W_ALT2;
        cnt_d   = CW'(ROWS + 1);
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if ((cnt_q == '0) && pipe_empty) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer registers; reset aborts any job and puts a bubble on the bus.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      vcnt_q   <= '0;
      b_out_q  <= '0;
      act_en_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vcnt_q   <= vcnt_d;
      b_out_q  <= b_out_d;
      act_en_q <= act_en_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  pe_seq_valid_pipe #(
    .DEPTH (ROWS + 1)
  ) u_valid_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (act_en_q),
    .cap_o   (pipe_cap),
    .valid_o (pipe_valid),
    .empty_o (pipe_empty)
  );

  // Result capture: validity comes only from the pipe, never from d_in data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data_q <= '0;
    end else if (pipe_cap) begin
      r_data_q <= d_in[15:0];
    end
  end

  // Upper D bits (flag/command lanes) carry nothing the sequencer needs.
  logic w_unused_dbits;
  assign w_unused_dbits = ^d_in[NB-1:16];

`ifdef PE_SEQ_PERF_EN
  logic [31:0] perf_q;

  // Busy-cycle counter: cleared by an accepted start, frozen while idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      perf_q <= '0;
    end else if (state_q != S_IDLE) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
`endif

  assign b_out         = b_out_q;
  assign act_en        = act_en_q;
  assign w_ready       = (state_q == S_WGT);
  assign bb_ready      = (state_q == S_BIAS);
  assign busy          = (state_q != S_IDLE);
  assign done          = done_q;
  assign err_underflow = err_q;
  assign r_valid       = pipe_valid;
  assign r_data        = r_data_q;

endmodule
`default_nettype wire
